// File: rtl/di_funct_capture.sv
// -----------------------------------------------------------------------------
// di_funct_capture
//   Conditions one raw digital input and measures it. The input goes through a
//   2-flop synchronizer, an optional debounce filter and an edge detector. The
//   conditioned edges then feed one of three functions: plain level, rising-edge
//   counting, or PWM period/high-time measurement.
//
// Parameters
//   FILTER_LEN  debounce length in clocks (1..255)
//   CNT_W       width of edge counter, period timer and high-time timer
//
// Ports
//   xclk            clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   di_in           raw input, asynchronous to xclk
//   which_function  0 LEVEL, 1 EDGE_COUNT, 2 PWM_MEAS, 3 reserved (as LEVEL)
//   filter_en       1 enables the debounce filter
//   clear_counts    synchronous clear of the measurement state
//   level_out       conditioned input level
//   rise_pulse      1-cycle pulse coincident with level_out rising
//   fall_pulse      1-cycle pulse coincident with level_out falling
//   edge_count      saturating rising-edge count (EDGE_COUNT)
//   period          last PWM period in clocks
//   high_time       last PWM high time in clocks
//   meas_valid      1-cycle strobe coincident with new period/high_time
//   overflow        sticky: edge counter saturation or PWM timeout
// -----------------------------------------------------------------------------
module di_funct_capture #(
    parameter int FILTER_LEN = 8,
    parameter int CNT_W      = 16
) (
    input  logic             xclk,
    input  logic             reset,
    input  logic             di_in,
    input  logic [1:0]       which_function,
    input  logic             filter_en,
    input  logic             clear_counts,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overflow
);

    localparam logic [1:0]       FN_EDGE   = 2'd1;
    localparam logic [1:0]       FN_PWM    = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } pwm_state_t;

    logic             sync1, sync2;
    logic [7:0]       filt_cnt;
    logic             filter_en_q;
    logic             filter_tgl;
    logic             level_nxt;
    logic [1:0]       fn_q;
    logic             fn_chg;
    pwm_state_t       state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] high_cap;

    assign filter_tgl = filter_en ^ filter_en_q;
    assign fn_chg     = which_function != fn_q;

    // ---------------------------------------------------------------- sync
    always_ff @(posedge xclk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= di_in;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------ filter
    // The cycle in which filter_en flips holds the level, so switching the
    // filter on or off can never create an edge by itself.
    always_comb begin
        level_nxt = level_out;
        if (filter_tgl)
            level_nxt = level_out;
        else if (!filter_en)
            level_nxt = sync2;
        else if (sync2 != level_out && filt_cnt == FILT_LAST)
            level_nxt = sync2;
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            filt_cnt    <= 8'd0;
            filter_en_q <= filter_en;   // no spurious toggle after reset
        end else begin
            filter_en_q <= filter_en;
            if (!filter_en || filter_tgl || sync2 == level_out ||
                filt_cnt == FILT_LAST)
                filt_cnt <= 8'd0;
            else
                filt_cnt <= filt_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------- level / edges
    always_ff @(posedge xclk) begin
        if (reset) begin
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            level_out  <= level_nxt;
            rise_pulse <= level_nxt & ~level_out;
            fall_pulse <= ~level_nxt & level_out;
        end
    end

    // --------------------------------------------------------- measurement
    // The timer is loaded with 1 on the cycle a rise pulse is consumed, so the
    // value sampled at the next rise (or fall) pulse equals the clock distance
    // between the two pulses.
    always_ff @(posedge xclk) begin
        if (reset) begin
            fn_q       <= which_function;   // mode set during reset is not a change
            state      <= WAIT_RISE;
            timer      <= '0;
            high_cap   <= '0;
            edge_count <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            fn_q       <= which_function;
            meas_valid <= 1'b0;
            if (clear_counts || fn_chg) begin
                // any rise_pulse this cycle is dropped on purpose
                state      <= WAIT_RISE;
                timer      <= '0;
                high_cap   <= '0;
                edge_count <= '0;
                period     <= '0;
                high_time  <= '0;
                overflow   <= 1'b0;
            end else if (which_function == FN_EDGE) begin
                state <= WAIT_RISE;
                if (rise_pulse) begin
                    if (edge_count == CNT_MAX)
                        overflow <= 1'b1;
                    else
                        edge_count <= edge_count + CNT_ONE;
                end
            end else if (which_function == FN_PWM) begin
                case (state)
                    WAIT_RISE: begin
                        if (rise_pulse) begin
                            state <= MEAS_HIGH;
                            timer <= CNT_ONE;
                        end
                    end
                    MEAS_HIGH: begin
                        if (timer == CNT_MAX) begin
                            overflow <= 1'b1;
                            state    <= WAIT_RISE;
                            timer    <= '0;
                        end else begin
                            timer <= timer + CNT_ONE;
                            if (fall_pulse) begin
                                high_cap <= timer;
                                state    <= MEAS_LOW;
                            end
                        end
                    end
                    MEAS_LOW: begin
                        if (timer == CNT_MAX) begin
                            overflow <= 1'b1;
                            state    <= WAIT_RISE;
                            timer    <= '0;
                        end else if (rise_pulse) begin
                            period     <= timer;
                            high_time  <= high_cap;
                            meas_valid <= 1'b1;
                            timer      <= CNT_ONE;
                            state      <= MEAS_HIGH;
                        end else begin
                            timer <= timer + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= WAIT_RISE;
                        timer <= '0;
                    end
                endcase
            end else begin
                // LEVEL and reserved: measurement outputs hold
                state <= WAIT_RISE;
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_di_funct_capture.sv
// -----------------------------------------------------------------------------
// tb_di_funct_capture
//   Random and patterned stimulus on di_in, mode, filter and clear inputs.
//   A reference model tracks the expected outputs from timestamps of the
//   conditioned edges and a history window of synchronized samples; every
//   output is compared on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_di_funct_capture;

    localparam int FL   = 8;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    localparam int ST_IDLE = 0;
    localparam int ST_HIGH = 1;
    localparam int ST_LOW  = 2;

    logic          xclk = 1'b0;
    logic          reset;
    logic          di_in;
    logic [1:0]    which_function;
    logic          filter_en;
    logic          clear_counts;
    logic          level_out, rise_pulse, fall_pulse, meas_valid, overflow;
    logic [CW-1:0] edge_count, period, high_time;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    always #5 xclk = ~xclk;

    di_funct_capture #(.FILTER_LEN(FL), .CNT_W(CW)) dut (
        .xclk(xclk), .reset(reset), .di_in(di_in),
        .which_function(which_function), .filter_en(filter_en),
        .clear_counts(clear_counts), .level_out(level_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_count(edge_count), .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .overflow(overflow)
    );

    // ------------------------------------------------------------ model
    int m_s1, m_s2, m_lvl, m_rise, m_fall;
    int m_fen_q, m_fn_q;
    int s2_hist[$];
    int m_ecnt, m_per, m_hi, m_mv, m_ovf;
    int m_st, t_rise, m_hcap;

    task automatic model_step();
        int rp, fp, nl, all_flip, age, sz;
        cyc_n++;
        rp = m_rise;
        fp = m_fall;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
            s2_hist.delete();
            m_fen_q = int'(filter_en);
            m_fn_q  = int'(which_function);
            m_ecnt = 0; m_per = 0; m_hi = 0; m_mv = 0; m_ovf = 0;
            m_st = ST_IDLE; m_hcap = 0; t_rise = 0;
            return;
        end
        // level: filter off follows the synchronized input; filter on flips
        // once the last FL synchronized samples all disagree with the level
        nl = m_lvl;
        if (int'(filter_en) != m_fen_q) begin
            s2_hist.delete();
        end else if (!filter_en) begin
            s2_hist.delete();
            nl = m_s2;
        end else begin
            s2_hist.push_back(m_s2);
            if (s2_hist.size() > 300) void'(s2_hist.pop_front());
            sz = s2_hist.size();
            if (sz >= FL) begin
                all_flip = 1;
                for (int i = 0; i < FL; i++)
                    if (s2_hist[sz-1-i] == m_lvl) all_flip = 0;
                if (all_flip != 0) nl = 1 - m_lvl;
            end
        end
        m_fen_q = int'(filter_en);
        m_rise  = (nl == 1 && m_lvl == 0) ? 1 : 0;
        m_fall  = (nl == 0 && m_lvl == 1) ? 1 : 0;
        m_lvl   = nl;
        m_s2    = m_s1;
        m_s1    = int'(di_in);

        // measurement
        m_mv = 0;
        if (clear_counts || int'(which_function) != m_fn_q) begin
            m_ecnt = 0; m_per = 0; m_hi = 0; m_ovf = 0; m_st = ST_IDLE;
        end else if (which_function == 2'd1) begin
            m_st = ST_IDLE;
            if (rp != 0) begin
                if (m_ecnt == MAXV) m_ovf = 1;
                else m_ecnt++;
            end
        end else if (which_function == 2'd2) begin
            age = cyc_n - t_rise;
            if (m_st == ST_IDLE) begin
                if (rp != 0) begin m_st = ST_HIGH; t_rise = cyc_n; end
            end else if (age == MAXV) begin
                m_ovf = 1; m_st = ST_IDLE;
            end else if (m_st == ST_HIGH) begin
                if (fp != 0) begin m_hcap = age; m_st = ST_LOW; end
            end else if (rp != 0) begin
                m_per = age; m_hi = m_hcap; m_mv = 1;
                t_rise = cyc_n; m_st = ST_HIGH;
            end
        end else begin
            m_st = ST_IDLE;
        end
        m_fn_q = int'(which_function);
    endtask

    // ------------------------------------------------------------ checks
    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
        end
    endtask

    task automatic check_all();
        chk("level_out",  int'(level_out),  m_lvl);
        chk("rise_pulse", int'(rise_pulse), m_rise);
        chk("fall_pulse", int'(fall_pulse), m_fall);
        chk("edge_count", int'(edge_count), m_ecnt);
        chk("period",     int'(period),     m_per);
        chk("high_time",  int'(high_time),  m_hi);
        chk("meas_valid", int'(meas_valid), m_mv);
        chk("overflow",   int'(overflow),   m_ovf);
    endtask

    // one clock: model follows the edge, outputs compared mid-cycle
    task automatic tick();
        @(posedge xclk);
        model_step();
        @(negedge xclk);
        check_all();
    endtask

    task automatic hold(input logic v, input int n);
        di_in = v;
        repeat (n) tick();
    endtask

    task automatic do_reset(input logic [1:0] fn, input logic fen);
        reset = 1'b1; which_function = fn; filter_en = fen;
        clear_counts = 1'b0; di_in = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        reset = 1'b1; di_in = 1'b0; which_function = 2'd0;
        filter_en = 1'b0; clear_counts = 1'b0;
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
        m_fen_q = 0; m_fn_q = 0; m_ecnt = 0; m_per = 0; m_hi = 0;
        m_mv = 0; m_ovf = 0; m_st = ST_IDLE; t_rise = 0; m_hcap = 0;

        // reset state, with di_in high to exercise the single rise on release
        di_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (6) tick();

        // LEVEL, filter off: random pulse widths including 1-clock pulses
        do_reset(2'd0, 1'b0);
        hold(1'b1, 4);
        hold(1'b0, 4);
        repeat (60) hold(~di_in, $urandom_range(1, 6));

        // LEVEL, filter on: directed 7-clock glitch and 20-clock pulse, then random
        do_reset(2'd0, 1'b1);
        hold(1'b0, 10);
        hold(1'b1, 7);
        hold(1'b0, 15);
        chk("glitch_rejected", int'(level_out), 0);
        hold(1'b1, 9);
        chk("filter_before", int'(level_out), 0);
        tick();
        chk("filter_edge10", int'(level_out), 1);
        hold(1'b1, 10);
        repeat (60) hold(~di_in, $urandom_range(1, 20));

        // EDGE_COUNT: saturate, then clear
        do_reset(2'd1, 1'b0);
        repeat (270) begin
            hold(1'b1, $urandom_range(1, 3));
            hold(1'b0, $urandom_range(1, 3));
        end
        hold(1'b0, 6);
        chk("edge_sat", int'(edge_count), MAXV);
        chk("edge_ovf", int'(overflow), 1);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        tick();
        chk("clr_count", int'(edge_count), 0);
        chk("clr_ovf", int'(overflow), 0);

        // PWM: 40 high / 60 low, then timeout, then reset during MEAS_LOW
        do_reset(2'd2, 1'b0);
        hold(1'b0, 5);
        repeat (5) begin
            hold(1'b1, 40);
            hold(1'b0, 60);
        end
        chk("pwm_period", int'(period), 100);
        chk("pwm_high", int'(high_time), 40);
        hold(1'b1, 300);
        chk("pwm_timeout_ovf", int'(overflow), 1);
        chk("pwm_period_hold", int'(period), 100);
        hold(1'b0, 20);
        hold(1'b1, 30);
        hold(1'b0, 10);
        reset = 1'b1;
        tick();
        chk("rst_mid_period", int'(period), 0);
        reset = 1'b0;

        // PWM then mode change 2->1 mid-measurement
        hold(1'b0, 5);
        hold(1'b1, 25);
        hold(1'b0, 35);
        hold(1'b1, 25);
        hold(1'b0, 10);
        which_function = 2'd1;
        hold(1'b0, 30);
        which_function = 2'd2;
        repeat (10) hold(~di_in, $urandom_range(3, 80));

        // mixed random traffic
        do_reset(2'd2, 1'b0);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) di_in = ~di_in;
            clear_counts = ($urandom_range(0, 199) == 0);
            reset        = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) which_function = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) filter_en = ~filter_en;
            tick();
        end
        reset = 1'b0;
        clear_counts = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/di_funct_capture.md
DI_FUNCT_CAPTURE -- requirements
Module: di_funct_capture

Interface
REQ-001 Parameter FILTER_LEN, default 8, sets the debounce length in clocks; the legal range is 1..255.
REQ-002 Parameter CNT_W, default 16, sets the width of the edge counter, period timer and high-time timer.
REQ-003 xclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 di_in  input  1  raw single-ended digital input; asynchronous to xclk.
REQ-006 which_function  input  2  selects the mode: 0 LEVEL, 1 EDGE_COUNT, 2 PWM_MEAS, 3 reserved (behaves as LEVEL).
REQ-007 filter_en  input  1  1 enables the debounce filter.
REQ-008 clear_counts  input  1  synchronous clear of the measurement state.
REQ-009 level_out  output  1  conditioned (synchronized and optionally filtered) input level.
REQ-010 rise_pulse  output  1  one-cycle pulse on each rising transition of level_out.
REQ-011 fall_pulse  output  1  one-cycle pulse on each falling transition of level_out.
REQ-012 edge_count  output  CNT_W  count of rising edges (EDGE_COUNT mode).
REQ-013 period  output  CNT_W  last measured PWM period, in clocks.
REQ-014 high_time  output  CNT_W  last measured PWM high time, in clocks.
REQ-015 meas_valid  output  1  one-cycle strobe when period and high_time update.
REQ-016 overflow  output  1  sticky flag for counter saturation or PWM timeout.

Function
REQ-017 di_in SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-018 Filter off: level_out SHALL register sync2, so a stable change on di_in appears at level_out on the 3rd xclk edge.
REQ-019 Filter on, mismatch handling: an 8-bit counter SHALL increment while sync2 != level_out and clear to 0 while they are equal.
REQ-020 Filter on, update: level_out SHALL take the value of sync2 on the edge where sync2 != level_out and the counter == FILTER_LEN-1; the counter SHALL then clear.
REQ-021 Filter on, latency: a stable change on di_in SHALL appear at level_out on edge 2+FILTER_LEN.
REQ-022 Filter on, glitch rejection: a pulse of fewer than FILTER_LEN clocks at sync2 SHALL be rejected.
REQ-023 Toggling filter_en SHALL clear the filter counter and SHALL NOT itself produce an edge pulse.
REQ-024 rise_pulse and fall_pulse SHALL be registered and SHALL assert in the same cycle that level_out takes its new value, for exactly 1 cycle.
REQ-025 Edges SHALL be detected in all modes, and the level and edge path SHALL NOT be affected by which_function.
REQ-026 EDGE_COUNT: edge_count SHALL increment by 1 on the cycle after each rise_pulse.
REQ-027 EDGE_COUNT: edge_count SHALL saturate at all-ones; a rise at saturation SHALL set overflow.
REQ-028 PWM_MEAS FSM states: WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-029 WAIT_RISE: on rise_pulse the FSM SHALL go to MEAS_HIGH with the timer set to 1.
REQ-030 MEAS_HIGH: the timer SHALL increment each clock; on fall_pulse the timer value SHALL be captured as high_cap and the FSM SHALL go to MEAS_LOW.
REQ-031 MEAS_LOW: the timer SHALL increment; on rise_pulse, period SHALL take the timer value, high_time SHALL take high_cap, the timer SHALL be set to 1, the FSM SHALL go to MEAS_HIGH, and meas_valid SHALL pulse 1 cycle later, coincident with the new values.
REQ-032 Measurement semantics: period SHALL equal the clocks between consecutive rise_pulses, and high_time SHALL equal the clocks from rise_pulse to fall_pulse.
REQ-033 PWM timeout: if the timer reaches all-ones in MEAS_HIGH or MEAS_LOW, overflow SHALL set, the FSM SHALL return to WAIT_RISE, and period and high_time SHALL hold their prior values.
REQ-034 In LEVEL and reserved modes, the FSM SHALL stay in WAIT_RISE, and edge_count, period and high_time SHALL hold.
REQ-035 A change of which_function, detected against its registered prior value, SHALL for one cycle clear edge_count, period, high_time, overflow and meas_valid, and send the FSM to WAIT_RISE.
REQ-036 clear_counts SHALL perform the same clear as a which_function change; a rise_pulse in the same cycle SHALL be discarded.
REQ-037 Priority SHALL be reset > clear_counts > which_function change > normal operation.
REQ-038 overflow SHALL remain set until reset, clear_counts or a which_function change.

Reset
REQ-039 While reset=1, the synchronizer flops, filter counter, level_out, rise_pulse, fall_pulse, edge_count, period, high_time, meas_valid and overflow SHALL be 0, and the FSM SHALL be in WAIT_RISE.
REQ-040 A reset asserted mid-measurement SHALL abort the measurement with no meas_valid, and it SHALL take effect on the first edge with reset=1.
REQ-041 After reset release, a di_in held at 1 SHALL produce exactly one rise_pulse once it propagates.

Verification
REQ-042 Filter off, di_in 0->1: level_out and rise_pulse go to 1 on edge 3; rise_pulse returns to 0 on edge 4.
REQ-043 FILTER_LEN=8, filter on: a 7-clock high glitch produces no change in level_out; a 20-clock high produces level_out=1 at edge 10 after the di_in change.
REQ-044 PWM_MEAS, di_in 40 clocks high / 60 clocks low, repeated: from the second rise onward, period=100, high_time=40, meas_valid 1-cycle pulses every 100 clocks.
REQ-045 EDGE_COUNT, CNT_W=4, 17 rising edges: edge_count stops at 15 and overflow=1 after the 16th edge; clear_counts then gives edge_count=0 and overflow=0.
REQ-046 PWM_MEAS, CNT_W=8, di_in held high after a rise: after 255 clocks overflow=1, the FSM is in WAIT_RISE, and period holds its prior value.
REQ-047 which_function changes 2->1 mid-measurement: counters clear, no meas_valid; reset asserted during MEAS_LOW: all outputs are 0 on the next edge.
